key_debouncer: RTL and testbench
================================

KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, stable-time in clocks (20 ms at 50 MHz); SHALL be >= 2.
REQ-002 Parameter LONG_PRESS_CYCLES, default 100000000, hold time for long press (2 s); SHALL be >= 2.
REQ-003 clk_50Mhz  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 key_n  input  1  raw board push-button, active-low, asynchronous, bouncing.
REQ-006 key_level  output  1  debounced level, 1 = pressed.
REQ-007 press_pulse  output  1  one-cycle strobe on accepted press; drives stopwatch start_pause.
REQ-008 release_pulse  output  1  one-cycle strobe on accepted release.
REQ-009 long_pulse  output  1  one-cycle strobe, once per press, after LONG_PRESS_CYCLES held.

Function
REQ-010 key_n SHALL pass through a two-flop synchronizer; key_sync = second flop, high = released.
REQ-011 Debounce counter SHALL be ceil(log2(DEBOUNCE_CYCLES)) bits and never wrap; hold counter ceil(log2(LONG_PRESS_CYCLES)) bits, saturating at LONG_PRESS_CYCLES-1.
REQ-012 FSM states SHALL be IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-013 IDLE: key_sync=0 -> PRESS_WAIT with debounce counter cleared; else stay.
REQ-014 PRESS_WAIT: key_sync=1 -> IDLE (bounce rejected, no pulse); key_sync=0 and counter=DEBOUNCE_CYCLES-1 -> PRESSED; else counter+1.
REQ-015 Entry to PRESSED from PRESS_WAIT SHALL assert press_pulse for exactly the first cycle in PRESSED, set key_level=1, clear hold counter and long_done flag.
REQ-016 Latency: key_n held low from sampling edge 0 SHALL give press_pulse=1 in the cycle following edge DEBOUNCE_CYCLES+2.
REQ-017 PRESSED: key_sync=1 -> RELEASE_WAIT with debounce counter cleared; else stay.
REQ-018 RELEASE_WAIT: key_sync=0 -> PRESSED without press_pulse and without clearing hold counter; key_sync=1 and counter=DEBOUNCE_CYCLES-1 -> IDLE; else counter+1.
REQ-019 Entry to IDLE from RELEASE_WAIT SHALL assert release_pulse for exactly one cycle and clear key_level in that same cycle.
REQ-020 Hold counter SHALL increment each cycle in PRESSED or RELEASE_WAIT; on reaching LONG_PRESS_CYCLES-1 with long_done=0, long_pulse SHALL be 1 for the next cycle and long_done set; no further long_pulse until IDLE re-entered.
REQ-021 If long threshold and release completion coincide, long_pulse SHALL fire and release_pulse in the same cycle.
REQ-022 press_pulse and release_pulse SHALL never be high in the same cycle; key_level SHALL be 1 exactly in PRESSED and RELEASE_WAIT.
REQ-023 All outputs SHALL be registered (no combinational path from key_n).

Reset
REQ-024 While reset=1 at a clock edge: state=IDLE, both synchronizer flops=1, both counters=0, long_done=0, all outputs=0.
REQ-025 Reset SHALL take priority over every transition, including mid-PRESS_WAIT and mid-PRESSED.
REQ-026 Key held through reset release SHALL be debounced afresh: press_pulse per REQ-016 counting from first post-reset edge.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10)
REQ-027 Reset 3 cycles, key_n=1 -> all outputs 0, state IDLE, no pulses for 20 cycles.
REQ-028 key_n low at edge 0, held -> press_pulse=1 only after edge 6; key_level=1 from edge 6; long_pulse=1 exactly once, after edge 16.
REQ-029 key_n low 3 cycles, high, repeat 5 times -> no press_pulse, key_level stays 0.
REQ-030 Pressed, key_n high 2 cycles then low -> no release_pulse, no second press_pulse; then high 10 cycles -> single release_pulse, key_level=0 same cycle.
REQ-031 reset=1 for 1 cycle while in PRESSED with key_n low -> outputs 0 next cycle; fresh press_pulse 6 edges after reset release.
REQ-032 Press held 8 cycles past press_pulse then released -> long_pulse at hold count 9 coinciding or preceding release_pulse per REQ-021; never repeated.

Source files
------------

// File: rtl/key_debouncer.sv
// Push-button debouncer: two-flop synchronizer, four-state debounce FSM and a
// long-press detector, with every output registered.
//
// state        | meaning
// IDLE         | key released and stable
// PRESS_WAIT   | key seen low, waiting for it to stay low
// PRESSED      | press accepted, key held
// RELEASE_WAIT | key seen high while pressed, waiting for it to stay high
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 100000000
) (
  input  logic clk_50Mhz,
  input  logic reset,
  input  logic key_n,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_PRESS_CYCLES);
  localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync2_q;
  logic [DW-1:0]   db_cnt_q, db_cnt_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic            long_done_q, long_done_d;
  logic            key_level_q, key_level_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            long_q, long_d;

  always_ff @(posedge clk_50Mhz) begin
    if (reset) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      db_cnt_q    <= '0;
      hold_cnt_q  <= '0;
      long_done_q <= 1'b0;
      key_level_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= key_n;
      sync2_q     <= sync1_q;
      db_cnt_q    <= db_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      long_done_q <= long_done_d;
      key_level_q <= key_level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    long_done_d = long_done_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;

    // Hold time keeps running through release bounces so a long press still fires.
    if (state_q == PRESSED || state_q == RELEASE_WAIT) begin
      if (hold_cnt_q == HOLD_MAX) begin
        if (!long_done_q) begin
          long_d      = 1'b1;
          long_done_d = 1'b1;
        end
      end else begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        long_done_d = 1'b0;
        if (!sync2_q) begin
          state_d  = PRESS_WAIT;
          db_cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (sync2_q) begin
          state_d = IDLE;
        end else if (db_cnt_q == DB_MAX) begin
          state_d     = PRESSED;
          press_d     = 1'b1;
          hold_cnt_d  = '0;
          long_done_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (sync2_q) begin
          state_d  = RELEASE_WAIT;
          db_cnt_d = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!sync2_q) begin
          state_d = PRESSED;
        end else if (db_cnt_q == DB_MAX) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    key_level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
  end

  assign key_level     = key_level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: directed vector table, hand-written corner sequences
// and random bouncing stimulus against a run-length reference model.
module tb_key_debouncer;

  localparam int D = 4;
  localparam int L = 10;

  logic clk = 1'b0;
  logic reset;
  logic key_n;
  logic key_level, press_pulse, release_pulse, long_pulse;

  always #5 clk = ~clk;

  key_debouncer #(.DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L)) dut (
    .clk_50Mhz    (clk),
    .reset        (reset),
    .key_n        (key_n),
    .key_level    (key_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse)
  );

  int errors = 0;
  int checks = 0;
  int n_press = 0, n_rel = 0, n_long = 0;

  // Reference model: a level change is accepted once the synchronized key has
  // disagreed with the debounced level for D+1 consecutive samples; long press
  // fires when L clock edges have elapsed since the press was accepted.
  bit m_s1, m_s2, m_level, m_press, m_rel, m_long;
  int m_run, m_elapsed;

  task automatic model_edge(input bit k, input bit r);
    bit s;
    m_press = 0; m_rel = 0; m_long = 0;
    if (r) begin
      m_s1 = 1; m_s2 = 1; m_level = 0; m_run = 0; m_elapsed = 0;
    end else begin
      s = m_s2; m_s2 = m_s1; m_s1 = k;
      if (m_level) begin
        m_elapsed++;
        m_long = (m_elapsed == L);
      end
      if ((!s) != m_level) m_run++;
      else m_run = 0;
      if (m_run == D + 1) begin
        m_run = 0;
        if (m_level) begin
          m_level = 0; m_rel = 1;
        end else begin
          m_level = 1; m_press = 1; m_elapsed = 0;
        end
      end
    end
  endtask

  task automatic check1(input string name, input logic act, input bit exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock edge: drive, advance model, sample 1 ns after the edge.
  task automatic step(input bit k, input bit r);
    key_n = k; reset = r;
    @(posedge clk);
    model_edge(k, r);
    #1;
    check1("press_pulse", press_pulse, m_press);
    check1("release_pulse", release_pulse, m_rel);
    check1("long_pulse", long_pulse, m_long);
    check1("key_level", key_level, m_level);
    if (press_pulse && release_pulse) check1("press_release_exclusive", 1'b1, 1'b0);
    if (press_pulse === 1'b1) n_press++;
    if (release_pulse === 1'b1) n_rel++;
    if (long_pulse === 1'b1) n_long++;
  endtask

  typedef struct {
    bit k; bit r;
    bit press; bit rel; bit lng; bit lvl;
  } vec_t;

  vec_t tbl[$];

  initial begin
    vec_t v;
    int p0, r0, l0, idx_press, idx_long, idx_rel, len;
    bit lvl_k;

    key_n = 1; reset = 1;
    for (int i = 0; i < 3; i++) tbl.push_back('{1, 1, 0, 0, 0, 0});
    for (int i = 0; i < 20; i++) tbl.push_back('{1, 0, 0, 0, 0, 0});
    for (int i = 0; i < 20; i++) begin
      v.k = 0; v.r = 0;
      v.press = (i == 6); v.rel = 0; v.lng = (i == 16); v.lvl = (i >= 6);
      tbl.push_back(v);
    end

    foreach (tbl[i]) begin
      key_n = tbl[i].k; reset = tbl[i].r;
      @(posedge clk);
      model_edge(tbl[i].k, tbl[i].r);
      #1;
      check1("tbl_press", press_pulse, tbl[i].press);
      check1("tbl_release", release_pulse, tbl[i].rel);
      check1("tbl_long", long_pulse, tbl[i].lng);
      check1("tbl_level", key_level, tbl[i].lvl);
    end

    // Release bounce while pressed: no release, no second press.
    p0 = n_press; r0 = n_rel;
    step(1, 0); step(1, 0);
    for (int i = 0; i < 6; i++) step(0, 0);
    check_int("bounce_no_release", n_rel - r0, 0);
    check_int("bounce_no_press", n_press - p0, 0);
    for (int i = 0; i < 10; i++) step(1, 0);
    check_int("single_release", n_rel - r0, 1);
    check1("level_after_release", key_level, 1'b0);

    // Short press bursts are rejected.
    p0 = n_press;
    for (int j = 0; j < 5; j++) begin
      step(0, 0); step(0, 0); step(0, 0); step(1, 0);
    end
    for (int i = 0; i < 4; i++) step(1, 0);
    check_int("short_bursts_no_press", n_press - p0, 0);
    check1("short_bursts_level", key_level, 1'b0);

    // Reset while pressed, key held through reset release.
    for (int i = 0; i < 10; i++) step(0, 0);
    check1("pressed_before_reset", key_level, 1'b1);
    step(0, 1);
    check1("reset_level", key_level, 1'b0);
    check1("reset_press", press_pulse, 1'b0);
    idx_press = -1;
    for (int i = 0; i < 12; i++) begin
      step(0, 0);
      if (press_pulse === 1'b1 && idx_press < 0) idx_press = i;
    end
    check_int("press_after_reset_edge", idx_press, 6);

    // Release, then press held 8 cycles past press_pulse, then released.
    for (int i = 0; i < 12; i++) step(1, 0);
    idx_press = -1;
    for (int i = 0; i < 20 && idx_press < 0; i++) begin
      step(0, 0);
      if (press_pulse === 1'b1) idx_press = i;
    end
    check1("long_case_press_seen", idx_press >= 0, 1'b1);
    l0 = n_long; idx_long = -1; idx_rel = -1;
    for (int i = 0; i < 8; i++) begin
      step(0, 0);
      if (long_pulse === 1'b1 && idx_long < 0) idx_long = i;
    end
    for (int i = 8; i < 24; i++) begin
      step(1, 0);
      if (long_pulse === 1'b1 && idx_long < 0) idx_long = i;
      if (release_pulse === 1'b1 && idx_rel < 0) idx_rel = i;
    end
    check_int("long_once", n_long - l0, 1);
    check1("release_seen", idx_rel >= 0, 1'b1);
    check1("long_not_after_release", (idx_long >= 0) && (idx_long <= idx_rel), 1'b1);

    // Random bouncing key with occasional reset.
    lvl_k = 1;
    for (int n = 0; n < 300; n++) begin
      lvl_k = ~lvl_k;
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++)
        step(lvl_k, ($urandom_range(0, 299) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
